// File: rtl/sdram_pkg.sv
// Shared defaults, capture-FSM state type and read-latency helper for the SDRAM read path.
// The latency helper honours SYNC_INPUT_DQ_REG_EN (extra input register stage).
package sdram_pkg;

    localparam int DQ_W_DEF      = 16;
    localparam int BURST_LEN_DEF = 4;
    localparam int CL_DEF        = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CAPT = 1'b1
    } capt_state_e;

    // Read latency in in_clk cycles: two in_clk cycles per SDRAM clock plus board delay.
    function automatic int calc_lat(input int cl, input int capture_ofs);
`ifdef SYNC_INPUT_DQ_REG_EN
        return 2 * cl + capture_ofs + 1;
`else
        return 2 * cl + capture_ofs;
`endif
    endfunction

endpackage

// File: rtl/sync_input_fifo.sv
// Two-entry synchronous FIFO; the head entry is a register driven straight to the outputs.
module sync_input_fifo #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         head_vld_q;
    logic         tail_vld_q;

    // Head/tail storage; a simultaneous push and pop on a full FIFO shifts and refills.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (!head_vld_q) begin
                        head_q     <= data_i;
                        head_vld_q <= 1'b1;
                    end else if (!tail_vld_q) begin
                        tail_q     <= data_i;
                        tail_vld_q <= 1'b1;
                    end else begin
                        tail_q <= tail_q;
                    end
                end
                2'b01: begin
                    head_q     <= tail_q;
                    head_vld_q <= tail_vld_q;
                    tail_vld_q <= 1'b0;
                end
                2'b11: begin
                    if (tail_vld_q) begin
                        head_q <= tail_q;
                        tail_q <= data_i;
                    end else begin
                        head_q     <= data_i;
                        head_vld_q <= 1'b1;
                    end
                end
                default: begin
                    head_q <= head_q;
                end
            endcase
        end
    end

    assign full_o  = tail_vld_q;
    assign empty_o = !head_vld_q;
    assign data_o  = head_q;

endmodule

// File: rtl/sync_input.sv
// DDR read-data capture: tracks reads through the CAS window and assembles each burst into one word.
// Optional build macro SYNC_INPUT_DQ_REG_EN adds an input register on dq_in (one extra cycle of latency).
module sync_input
    import sdram_pkg::*;
#(
    parameter int DQ_W        = DQ_W_DEF,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int CL          = CL_DEF,
    parameter int CAPTURE_OFS = 1
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      rd_issue,
    input  logic [DQ_W-1:0]           dq_in,
    output logic [DQ_W*BURST_LEN-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      busy,
    output logic                      overflow,
    output logic                      proto_err
);

    localparam int LAT = calc_lat(CL, CAPTURE_OFS);
    localparam int CW  = $clog2(BURST_LEN);
    localparam int WW  = DQ_W * BURST_LEN;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [LAT-1:0]  sr_q;
    logic [LAT-1:0]  sr_d;
    capt_state_e     state_q;
    logic [CW-1:0]   beat_q;
    logic [DQ_W-1:0] beats_q [BURST_LEN-1];
    logic [DQ_W-1:0] dq_s;
    logic [WW-1:0]   word_s;
    logic            tap_s;
    logic            last_s;
    logic            pop_s;
    logic            push_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;

`ifdef SYNC_INPUT_DQ_REG_EN
    logic [DQ_W-1:0] dq_q;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            dq_q <= '0;
        end else begin
            dq_q <= dq_in;
        end
    end

    assign dq_s = dq_q;
`else
    assign dq_s = dq_in;
`endif

    // The tap fires one cycle ahead so that beat 0 is sampled in the first CAPT cycle.
    assign sr_d   = {sr_q[LAT-2:0], rd_issue};
    assign tap_s  = sr_q[LAT-2];
    assign last_s = (state_q == ST_CAPT) && (beat_q == LAST_BEAT);
    assign pop_s  = rd_valid && rd_ready;
    assign push_s = last_s && (!fifo_full_s || pop_s);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            proto_err <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < BURST_LEN - 1; i++) begin
                beats_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    beat_q <= '0;
                    if (tap_s) begin
                        state_q <= ST_CAPT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CAPT: begin
                    if (beat_q == LAST_BEAT) begin
                        beat_q <= '0;
                        if (tap_s) begin
                            state_q <= ST_CAPT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        beats_q[beat_q] <= dq_s;
                        beat_q          <= beat_q + CW'(1);
                        if (tap_s) begin
                            proto_err <= 1'b1;
                        end else begin
                            proto_err <= proto_err;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    beat_q  <= '0;
                end
            endcase
            if (last_s && fifo_full_s && !pop_s) begin
                overflow <= 1'b1;
            end else begin
                overflow <= overflow;
            end
        end
    end

    // The last beat bypasses the beat store and goes straight into the FIFO word.
    always_comb begin
        word_s = '0;
        for (int i = 0; i < BURST_LEN - 1; i++) begin
            word_s[i*DQ_W +: DQ_W] = beats_q[i];
        end
        word_s[WW-1 -: DQ_W] = dq_s;
    end

    sync_input_fifo #(
        .W (WW)
    ) u_fifo (
        .clk_i   (in_clk),
        .rst_ni  (in_rst),
        .push_i  (push_s),
        .data_i  (word_s),
        .pop_i   (pop_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .data_o  (rd_data)
    );

    assign rd_valid = !fifo_empty_s;
    assign busy     = (|sr_q) || (state_q == ST_CAPT);

endmodule
